// File: rtl/slice_acc_pkg.sv
// Shared definitions for the bit-slice result accumulator.
// Contents:
//   state_e    - control FSM states
//   fuse_width - width of the fused (summed) PE sub-results
//   term_width - width of a fused and slice-shifted term
//   sat_max    - most positive value of an acc_w-bit signed accumulator
//   sat_min    - most negative value of an acc_w-bit signed accumulator
package slice_acc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StHold
    } state_e;

    // Saturation limits are produced at this width and narrowed by the user.
    localparam int unsigned LimW = 64;

    function automatic int unsigned fuse_width(input int unsigned part_w,
                                               input int unsigned num_parts);
        return part_w + $clog2(num_parts);
    endfunction

    function automatic int unsigned term_width(input int unsigned part_w,
                                               input int unsigned num_parts,
                                               input int unsigned digit_w,
                                               input int unsigned num_slices);
        return fuse_width(part_w, num_parts) + digit_w * (num_slices - 1);
    endfunction

    function automatic logic signed [LimW-1:0] sat_max(input int unsigned acc_w);
        logic signed [LimW-1:0] one;
        one = LimW'(1);
        return (one <<< (acc_w - 1)) - one;
    endfunction

    function automatic logic signed [LimW-1:0] sat_min(input int unsigned acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/slice_acc_lane.sv
// One accumulator lane: fuses the NUM_PARTS sub-results of a single PE,
// shifts the fused value by DIGIT_W*slice, registers it (stage S1) and adds
// it into a saturating or wrapping ACC_W-bit accumulator.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear of S1, accumulator and overflow flag
//   sat_en    - 1: clamp on overflow, 0: keep low ACC_W bits
//   load      - accepted beat with an in-range slice; otherwise S1 loads 0
//   slice     - slice index of the beat
//   parts     - NUM_PARTS signed sub-results, part p at [p*PART_W +: PART_W]
//   acc       - accumulator value
//   ovf       - sticky overflow flag
module slice_acc_lane
    import slice_acc_pkg::*;
#(
    parameter int unsigned NUM_PARTS  = 2,
    parameter int unsigned PART_W     = 26,
    parameter int unsigned DIGIT_W    = 2,
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned SLICE_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          sat_en,
    input  logic                          load,
    input  logic [SLICE_W-1:0]            slice,
    input  logic [NUM_PARTS*PART_W-1:0]   parts,
    output logic [ACC_W-1:0]              acc,
    output logic                          ovf
);

    localparam int unsigned FuseW = fuse_width(PART_W, NUM_PARTS);
    localparam int unsigned TermW = term_width(PART_W, NUM_PARTS, DIGIT_W, NUM_SLICES);
    // One guard bit above the wider operand keeps the raw sum exact.
    localparam int unsigned AddW  = ((TermW > ACC_W) ? TermW : ACC_W) + 1;

    localparam logic signed [AddW-1:0] MaxV = AddW'(sat_max(ACC_W));
    localparam logic signed [AddW-1:0] MinV = AddW'(sat_min(ACC_W));

    logic signed [FuseW-1:0] fused;
    logic signed [TermW-1:0] term;
    logic signed [TermW-1:0] term_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [AddW-1:0]  sum;
    logic                    ovf_now;
    logic                    ovf_q;

    // Fuse and shift.
    always_comb begin
        fused = '0;
        for (int p = 0; p < NUM_PARTS; p++) begin
            fused = fused + FuseW'($signed(parts[p*PART_W +: PART_W]));
        end
        term = TermW'(fused) <<< (DIGIT_W * 32'(slice));
    end

    // Accumulate. S1 holds 0 whenever no beat was loaded, so adding it every
    // cycle leaves the accumulator and the overflow flag untouched.
    always_comb begin
        sum     = AddW'(acc_q) + AddW'(term_q);
        ovf_now = (sum > MaxV) || (sum < MinV);
        acc_d   = ACC_W'(sum);
        if (ovf_now && sat_en) begin
            acc_d = (sum > MaxV) ? ACC_W'(MaxV) : ACC_W'(MinV);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            term_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            term_q <= load ? term : '0;
            acc_q  <= acc_d;
            ovf_q  <= ovf_q | ovf_now;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/slice_accumulate_unit.sv
// Bit-slice result accumulator behind the PE array. Accepts per-slice PE
// partial results for CHANNELS PEs, fuses/shifts/accumulates them per lane
// and returns the final dot-product results over a ready/valid port.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start                - begin (or abort and restart) a dot product
//   sat_en               - saturating (1) or wrapping (0) add, latched on start
//   in_valid, in_ready   - input beat handshake
//   in_slice, in_last    - slice index of the beat, final beat marker
//   pe_result            - channel c, part p at [(c*NUM_PARTS+p)*PART_W +: PART_W]
//   out_valid, out_ready - result handshake
//   out_data             - signed result for channel c at [c*ACC_W +: ACC_W]
//   out_ovf              - per-channel sticky overflow
//   slice_err            - sticky out-of-range slice flag
//   busy                 - FSM not idle
module slice_accumulate_unit
    import slice_acc_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned NUM_PARTS  = 2,
    parameter int unsigned PART_W     = 26,
    parameter int unsigned DIGIT_W    = 2,
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned ACC_W      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  sat_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [$clog2(NUM_SLICES)-1:0]         in_slice,
    input  logic                                  in_last,
    input  logic [CHANNELS*NUM_PARTS*PART_W-1:0]  pe_result,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CHANNELS*ACC_W-1:0]             out_data,
    output logic [CHANNELS-1:0]                   out_ovf,
    output logic                                  slice_err,
    output logic                                  busy
);

    localparam int unsigned LaneW = NUM_PARTS * PART_W;

    state_e state_q;
    state_e state_d;
    logic   sat_q;
    logic   err_q;
    logic   clear;
    logic   accept;
    logic   slice_bad;
    logic   load;

    // start is ignored in HOLD so that pending results are never lost.
    assign clear     = start && (state_q != StHold);
    // A beat presented together with start is dropped.
    assign accept    = in_valid && in_ready && !start;
    assign slice_bad = 32'(in_slice) >= NUM_SLICES;
    assign load      = accept && !slice_bad;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAccum;
            StAccum: begin
                if (start) begin
                    state_d = StAccum;
                end else if (in_valid && in_last) begin
                    state_d = StDrain;
                end
            end
            // One cycle for the last S1 term to reach the accumulator.
            StDrain: state_d = start ? StAccum : StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle:  busy      = 1'b0;
            StAccum: in_ready  = 1'b1;
            StDrain: ;
            StHold:  out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else if (clear) begin
            sat_q <= sat_en;
            err_q <= 1'b0;
        end else if (accept && slice_bad) begin
            err_q <= 1'b1;
        end
    end

    assign slice_err = err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        slice_acc_lane #(
            .NUM_PARTS  (NUM_PARTS),
            .PART_W     (PART_W),
            .DIGIT_W    (DIGIT_W),
            .NUM_SLICES (NUM_SLICES),
            .ACC_W      (ACC_W),
            .SLICE_W    ($clog2(NUM_SLICES))
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .sat_en (sat_q),
            .load   (load),
            .slice  (in_slice),
            .parts  (pe_result[c*LaneW +: LaneW]),
            .acc    (out_data[c*ACC_W +: ACC_W]),
            .ovf    (out_ovf[c])
        );
    end

endmodule

// File: tb/tb_slice_accumulate_unit.sv
module tb_slice_accumulate_unit;

    localparam int CH  = 4;
    localparam int NP  = 2;
    localparam int PW  = 26;
    localparam int DW  = 2;
    localparam int NSL = 4;
    localparam int AW  = 32;
    localparam longint MaxV = 64'sd2147483647;
    localparam longint MinV = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              sat_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_slice = '0;
    logic              in_last = 1'b0;
    logic [CH*NP*PW-1:0] pe_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH*AW-1:0]  out_data;
    logic [CH-1:0]     out_ovf;
    logic              slice_err;
    logic              busy;

    // Second instance with NUM_SLICES=3 so a 2-bit slice index can be out of range.
    logic              s_start = 1'b0;
    logic              s_sat = 1'b0;
    logic              s_in_valid = 1'b0;
    logic              s_in_ready;
    logic [1:0]        s_in_slice = '0;
    logic              s_in_last = 1'b0;
    logic [NP*PW-1:0]  s_pe = '0;
    logic              s_out_valid;
    logic              s_out_ready = 1'b0;
    logic [AW-1:0]     s_out_data;
    logic [0:0]        s_out_ovf;
    logic              s_slice_err;
    logic              s_busy;

    slice_accumulate_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sat_en    (sat_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .in_last   (in_last),
        .pe_result (pe_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .slice_err (slice_err),
        .busy      (busy)
    );

    slice_accumulate_unit #(
        .CHANNELS   (1),
        .NUM_SLICES (3)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .sat_en    (s_sat),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_slice  (s_in_slice),
        .in_last   (s_in_last),
        .pe_result (s_pe),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_ovf   (s_out_ovf),
        .slice_err (s_slice_err),
        .busy      (s_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: exact per-channel sums with per-add overflow handling.
    longint m_acc[CH];
    bit     m_ovf[CH];
    bit     m_err = 1'b0;
    bit     m_sat = 1'b0;
    int     pv[CH][NP];

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic longint dch(input int c);
        logic signed [AW-1:0] v;
        v = out_data[c*AW +: AW];
        return longint'(v);
    endfunction

    function automatic void model_clear(input bit sat);
        m_sat = sat;
        m_err = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0;
            m_ovf[c] = 1'b0;
        end
    endfunction

    function automatic void model_add(input int c, input longint term);
        longint s;
        logic signed [AW-1:0] lo;
        s = m_acc[c] + term;
        if (s > MaxV || s < MinV) begin
            m_ovf[c] = 1'b1;
            if (m_sat) begin
                s = (s > MaxV) ? MaxV : MinV;
            end else begin
                lo = s[AW-1:0];
                s  = longint'(lo);
            end
        end
        m_acc[c] = s;
    endfunction

    function automatic int dig(input int bv, input int s);
        if (s == NSL - 1) return bv >>> (DW * s);
        return (bv >> (DW * s)) & 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pe();
        for (int c = 0; c < CH; c++) begin
            for (int p = 0; p < NP; p++) begin
                pe_result[(c*NP+p)*PW +: PW] = PW'(pv[c][p]);
            end
        end
    endtask

    task automatic do_start(input bit sat);
        start  = 1'b1;
        sat_en = sat;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        model_clear(sat);
    endtask

    task automatic beat(input int slice, input bit last);
        longint term;
        drive_pe();
        in_slice = 2'(slice);
        in_last  = last;
        in_valid = 1'b1;
        chk("in_ready_accum", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            term = (slice < NSL) ? longint'(pv[c][0] + pv[c][1]) * (64'sd1 <<< (DW * slice)) : 0;
            model_add(c, term);
        end
        if (slice >= NSL) m_err = 1'b1;
    endtask

    task automatic wait_hold(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, longint'(out_valid), 1);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk(name, longint'(out_valid), 0);
        chk({name, "_busy"}, longint'(busy), 0);
    endtask

    // Compare process: outputs against the model whenever they are meaningful.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_slice_err", longint'(slice_err), longint'(m_err));
            if (out_valid) begin
                for (int c = 0; c < CH; c++) begin
                    chk("cmp_data", dch(c), m_acc[c]);
                    chk("cmp_ovf", longint'(out_ovf[c]), longint'(m_ovf[c]));
                end
                chk("cmp_hold_in_ready", longint'(in_ready), 0);
                chk("cmp_hold_busy", longint'(busy), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int a[CH][32];
        int b[CH][32];
        longint ref_v[CH];
        logic signed [AW-1:0] sv;
        int n;

        for (int c = 0; c < CH; c++) for (int p = 0; p < NP; p++) pv[c][p] = 0;
        model_clear(1'b0);

        // Reset state.
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_data", longint'(out_data != '0), 0);
        chk("rst_slice_err", longint'(slice_err), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Out-of-range slice on the NUM_SLICES=3 instance.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("s_err_clear", longint'(s_slice_err), 0);
        s_pe = {26'(2), 26'(1)};
        s_in_slice = 2'd1;
        s_in_valid = 1'b1;
        chk("s_in_ready", longint'(s_in_ready), 1);
        tick();
        s_pe = {26'(7), 26'(7)};
        s_in_slice = 2'd3;
        s_in_last = 1'b1;
        tick();
        s_in_valid = 1'b0;
        s_in_last = 1'b0;
        chk("s_err_set", longint'(s_slice_err), 1);
        n = 0;
        while (s_out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("s_valid", longint'(s_out_valid), 1);
        sv = s_out_data;
        chk("s_data", longint'(sv), 12);
        chk("s_ovf", longint'(s_out_ovf), 0);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("s_idle", longint'(s_busy), 0);
        chk("s_err_sticky", longint'(s_slice_err), 1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("s_err_restart", longint'(s_slice_err), 0);

        // Basic fuse/shift with latency.
        pv[0][0] = 100;
        pv[0][1] = -30;
        do_start(1'b0);
        beat(3, 1'b1);
        chk("lat_drain", longint'(out_valid), 0);
        tick();
        chk("lat_hold", longint'(out_valid), 1);
        chk("basic_model", m_acc[0], 4480);
        chk("basic_data", dch(0), 4480);
        chk("basic_ovf", longint'(out_ovf), 0);
        consume("basic_done");

        // Saturating and wrapping overflow.
        for (int c = 0; c < CH; c++) for (int p = 0; p < NP; p++) pv[c][p] = 33554431;
        for (int m = 0; m < 2; m++) begin
            do_start(m == 0);
            for (int i = 0; i < 8; i++) beat(3, i == 7);
            wait_hold("ovf_valid");
            chk("ovf_model", m_acc[0], (m == 0) ? 2147483647 : -1024);
            chk("ovf_data", dch(0), (m == 0) ? 2147483647 : -1024);
            chk("ovf_flag", longint'(out_ovf), 15);
            consume("ovf_done");
        end

        // Backpressure with a start pulse ignored in HOLD.
        for (int c = 0; c < CH; c++) begin
            pv[c][0] = 10 * (c + 1);
            pv[c][1] = c;
        end
        do_start(1'b0);
        for (int s = 0; s < NSL; s++) beat(s, s == NSL - 1);
        wait_hold("bp_valid");
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            start = 1'b0;
            chk("bp_valid_held", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_data", dch(1), 1785);
        end
        consume("bp_release");

        // start together with out_ready in HOLD is not honoured.
        do_start(1'b0);
        beat(0, 1'b1);
        wait_hold("so_valid");
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("so_busy", longint'(busy), 0);
        tick();
        chk("so_still_idle", longint'(busy), 0);

        // Abort after 3 beats; the beat presented with start is dropped.
        for (int c = 0; c < CH; c++) begin
            pv[c][0] = 5;
            pv[c][1] = 6;
        end
        do_start(1'b0);
        for (int i = 0; i < 3; i++) beat(i, 1'b0);
        drive_pe();
        in_slice = 2'd1;
        in_valid = 1'b1;
        do_start(1'b0);
        for (int c = 0; c < CH; c++) begin
            pv[c][0] = 3;
            pv[c][1] = 4;
        end
        beat(2, 1'b1);
        wait_hold("abort_valid");
        chk("abort_data", dch(0), 112);
        consume("abort_done");

        // Full inner products with radix-4 digit slices of b.
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < CH; c++) begin
                ref_v[c] = 0;
                for (int k = 0; k < 32; k++) begin
                    a[c][k] = int'($urandom_range(255)) - 128;
                    b[c][k] = int'($urandom_range(255)) - 128;
                    ref_v[c] += longint'(a[c][k] * b[c][k]);
                end
            end
            do_start(1'b0);
            for (int g = 0; g < 8; g++) begin
                for (int s = 0; s < NSL; s++) begin
                    for (int c = 0; c < CH; c++) begin
                        for (int p = 0; p < NP; p++) begin
                            pv[c][p] = a[c][4*g+2*p] * dig(b[c][4*g+2*p], s)
                                     + a[c][4*g+2*p+1] * dig(b[c][4*g+2*p+1], s);
                        end
                    end
                    beat(s, g == 7 && s == NSL - 1);
                end
            end
            wait_hold("dot_valid");
            for (int c = 0; c < CH; c++) begin
                chk("dot_model", m_acc[c], ref_v[c]);
                chk("dot_data", dch(c), ref_v[c]);
            end
            consume("dot_done");
        end

        // Reset while in DRAIN, then a fresh dot product.
        for (int c = 0; c < CH; c++) begin
            pv[c][0] = 9;
            pv[c][1] = 9;
        end
        do_start(1'b0);
        beat(0, 1'b0);
        beat(1, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", longint'(in_ready), 0);
        chk("mrst_out_valid", longint'(out_valid), 0);
        chk("mrst_busy", longint'(busy), 0);
        chk("mrst_out_data", longint'(out_data != '0), 0);
        chk("mrst_ovf", longint'(out_ovf), 0);
        chk("mrst_slice_err", longint'(slice_err), 0);
        model_clear(1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        pv[2][0] = -8;
        pv[2][1] = 3;
        do_start(1'b0);
        beat(2, 1'b1);
        wait_hold("post_rst_valid");
        chk("post_rst_data", dch(2), -80);
        consume("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
